morse_timebase: RTL

Parametrised timebase for the Morse datapath, successor to the fixed 50 MHz half-second/second divider. It keeps the free-running half-second and second counters and adds a second, runtime-programmable divider that produces the Morse dot-unit tick. The keyer, decoder and LCD scroller consume its one-cycle tick pulses and counters. The unit period is reloaded through a pulse/acknowledge handshake without glitching the tick stream.

---
 rtl/morse_timebase.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/morse_timebase.sv
// Morse datapath timebase: free-running half-second/second divider plus a
// runtime-programmable dot-unit divider whose period reloads glitch-free.
module morse_timebase #(
    parameter int CLK_HZ           = 50_000_000,
    parameter int DIV_W            = 26,
    parameter int DEFAULT_UNIT_CYC = 6_000_000,
    parameter int UNIT_W           = 8,
    parameter int SEC_W            = 4
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              iEn,
    input  logic              iClr,
    input  logic              iLoad,
    input  logic [DIV_W-1:0]  iUnitCyc,
    output logic              oLoadAck,
    output logic              oUnitTick,
    output logic [UNIT_W-1:0] oUnitCnt,
    output logic              oHalfSecTick,
    output logic              oSecTick,
    output logic [SEC_W-1:0]  oHalfSec,
    output logic [SEC_W-1:0]  oSec
);

    localparam int               HALF_CYC   = CLK_HZ / 2;
    localparam logic [DIV_W-1:0] HALF_LAST  = DIV_W'(HALF_CYC - 1);
    localparam logic [DIV_W-1:0] DEF_PERIOD = DIV_W'(DEFAULT_UNIT_CYC);
    localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(2);

    logic [DIV_W-1:0]  half_cnt_q,  half_cnt_d;
    logic [SEC_W-1:0]  half_sec_q,  half_sec_d;
    logic [SEC_W-1:0]  sec_q,       sec_d;
    logic              half_tick_q, half_tick_d;
    logic              sec_tick_q,  sec_tick_d;

    logic [DIV_W-1:0]  unit_div_q,  unit_div_d;
    logic [DIV_W-1:0]  period_q,    period_d;
    logic [DIV_W-1:0]  pend_q,      pend_d;
    logic              pend_vld_q,  pend_vld_d;
    logic              unit_tick_q, unit_tick_d;
    logic [UNIT_W-1:0] unit_cnt_q,  unit_cnt_d;
    logic              load_ack_q,  load_ack_d;

    logic [DIV_W-1:0]  load_val;
    logic [DIV_W-1:0]  apply_val;
    logic              apply_vld;
    logic              unit_term;

    // Load handshake: iLoad is a one-cycle request with no ready; the value
    // waits in pend_q until a unit boundary (terminal or clear), where it is
    // committed and oLoadAck pulses once. A newer request overwrites it.
    always_comb begin
        load_val  = (iUnitCyc < MIN_PERIOD) ? MIN_PERIOD : iUnitCyc;
        apply_vld = iLoad | pend_vld_q;
        apply_val = iLoad ? load_val : pend_q;
        unit_term = iEn && (unit_div_q == period_q - DIV_W'(1));
    end

    always_comb begin
        half_cnt_d  = half_cnt_q;
        half_sec_d  = half_sec_q;
        sec_d       = sec_q;
        half_tick_d = 1'b0;
        sec_tick_d  = 1'b0;

        if (iEn) begin
            if (half_cnt_q == HALF_LAST) begin
                half_cnt_d  = '0;
                half_tick_d = 1'b1;
                half_sec_d  = half_sec_q + SEC_W'(1);
                if (half_sec_q[0]) begin
                    sec_d      = sec_q + SEC_W'(1);
                    sec_tick_d = 1'b1;
                end
            end else begin
                half_cnt_d = half_cnt_q + DIV_W'(1);
            end
        end
    end

    always_comb begin
        unit_div_d  = unit_div_q;
        period_d    = period_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        unit_cnt_d  = unit_cnt_q;
        unit_tick_d = 1'b0;
        load_ack_d  = 1'b0;

        if (iLoad) begin
            pend_d     = load_val;
            pend_vld_d = 1'b1;
        end

        // Clear outranks the terminal event and swallows its tick.
        if (iClr || unit_term) begin
            unit_div_d = '0;
            if (iClr) begin
                unit_cnt_d = '0;
            end else begin
                unit_tick_d = 1'b1;
                if (unit_cnt_q != '1) begin
                    unit_cnt_d = unit_cnt_q + UNIT_W'(1);
                end
            end
            if (apply_vld) begin
                period_d   = apply_val;
                pend_vld_d = 1'b0;
                load_ack_d = 1'b1;
            end
        end else if (iEn) begin
            unit_div_d = unit_div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            half_cnt_q  <= '0;
            half_sec_q  <= '0;
            sec_q       <= '0;
            half_tick_q <= 1'b0;
            sec_tick_q  <= 1'b0;
            unit_div_q  <= '0;
            period_q    <= DEF_PERIOD;
            pend_q      <= DEF_PERIOD;
            pend_vld_q  <= 1'b0;
            unit_tick_q <= 1'b0;
            unit_cnt_q  <= '0;
            load_ack_q  <= 1'b0;
        end else begin
            half_cnt_q  <= half_cnt_d;
            half_sec_q  <= half_sec_d;
            sec_q       <= sec_d;
            half_tick_q <= half_tick_d;
            sec_tick_q  <= sec_tick_d;
            unit_div_q  <= unit_div_d;
            period_q    <= period_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            unit_tick_q <= unit_tick_d;
            unit_cnt_q  <= unit_cnt_d;
            load_ack_q  <= load_ack_d;
        end
    end

    assign oLoadAck     = load_ack_q;
    assign oUnitTick    = unit_tick_q;
    assign oUnitCnt     = unit_cnt_q;
    assign oHalfSecTick = half_tick_q;
    assign oSecTick     = sec_tick_q;
    assign oHalfSec     = half_sec_q;
    assign oSec         = sec_q;

endmodule
